// File: rtl/iic_slave_mem_if.sv
`timescale 1ns/1ps
// Bus-side bundle of the EEPROM-style I2C target: SCL from the master plus the
// write-status outputs consumed by the display logic.
interface iic_slave_mem_if;
    logic       scl;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] last_wr;
    logic       busy;

    modport slave  (input scl, output wr_pulse, wr_addr, last_wr, busy);
    modport master (output scl, input wr_pulse, wr_addr, last_wr, busy);
endinterface

// File: rtl/iic_slave_mem.sv
`timescale 1ns/1ps
// I2C target emulating a small byte-addressed EEPROM: byte/sequential write, random
// read via repeated START, current-address sequential read; reports the last written byte.
module iic_slave_mem #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEPTH    = 16
) (
    input  logic           clk,
    input  logic           rst,
    inout  wire            sda,
    iic_slave_mem_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_ACK_DW, ST_ACK_DR, ST_WORD_ADDR, ST_ACK_WA,
        ST_WR_DATA, ST_ACK_WR, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t          state_r, state_s;
    logic [2:0]      scl_sync_r, sda_sync_r;
    logic [3:0]      cnt_r, cnt_s;
    logic [7:0]      sh_r, sh_s;
    logic [PW-1:0]   ptr_r, ptr_s;
    logic            sda_low_r, sda_low_s;
    logic            busy_r, busy_s;
    logic            commit_s;
    logic [7:0]      rd_byte_s;
    logic [7:0]      mem_r [DEPTH];
    logic            wr_pulse_r;
    logic [7:0]      wr_addr_r, last_wr_r;
    logic            scl_rise_s, scl_fall_s, start_s, stop_s, sda_in_s;

    // Stage [1] is the synchronised level, stage [2] the previous sample for edge detection.
    assign sda_in_s   = sda_sync_r[1];
    assign scl_rise_s = scl_sync_r[1] & ~scl_sync_r[2];
    assign scl_fall_s = ~scl_sync_r[1] & scl_sync_r[2];
    assign start_s    = scl_sync_r[1] & scl_sync_r[2] & sda_sync_r[2] & ~sda_sync_r[1];
    assign stop_s     = scl_sync_r[1] & scl_sync_r[2] & ~sda_sync_r[2] & sda_sync_r[1];
    assign rd_byte_s  = mem_r[ptr_r];

    assign sda          = sda_low_r ? 1'b0 : 1'bz;
    assign bus.wr_pulse = wr_pulse_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.last_wr  = last_wr_r;
    assign bus.busy     = busy_r;

    // Input synchronisers, reset to the idle-bus level so reset release is not a bus event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_r <= 3'b111;
            sda_sync_r <= 3'b111;
        end else begin
            scl_sync_r <= {scl_sync_r[1:0], bus.scl};
            sda_sync_r <= {sda_sync_r[1:0], sda};
        end
    end

    // Protocol decisions, taken only on a detected SCL edge or a START/STOP condition.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sh_s      = sh_r;
        ptr_s     = ptr_r;
        sda_low_s = sda_low_r;
        busy_s    = busy_r;
        commit_s  = 1'b0;
        if (stop_s) begin
            state_s   = ST_IDLE;
            cnt_s     = 4'd0;
            sda_low_s = 1'b0;
            busy_s    = 1'b0;
        end else if (start_s) begin
            state_s   = ST_DEV_ADDR;
            cnt_s     = 4'd0;
            sda_low_s = 1'b0;
        end else begin
            case (state_r)
                ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
                    if (scl_rise_s && cnt_r != 4'd8) begin
                        sh_s  = {sh_r[6:0], sda_in_s};
                        cnt_s = cnt_r + 4'd1;
                    end else if (scl_fall_s && cnt_r == 4'd8) begin
                        cnt_s     = 4'd0;
                        sda_low_s = 1'b1;
                        if (state_r == ST_DEV_ADDR) begin
                            if (sh_r[7:1] == DEV_ADDR) begin
                                busy_s  = 1'b1;
                                state_s = sh_r[0] ? ST_ACK_DR : ST_ACK_DW;
                            end else begin
                                busy_s    = 1'b0;
                                sda_low_s = 1'b0;
                                state_s   = ST_IGNORE;
                            end
                        end else if (state_r == ST_WORD_ADDR) begin
                            ptr_s   = sh_r[PW-1:0];
                            state_s = ST_ACK_WA;
                        end else begin
                            commit_s = 1'b1;
                            ptr_s    = ptr_r + PW'(1);
                            state_s  = ST_ACK_WR;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_ACK_DW, ST_ACK_WA, ST_ACK_WR: begin
                    if (scl_fall_s) begin
                        sda_low_s = 1'b0;
                        state_s   = (state_r == ST_ACK_DW) ? ST_WORD_ADDR : ST_WR_DATA;
                    end else begin
                        sda_low_s = 1'b1;
                    end
                end
                ST_ACK_DR: begin
                    if (scl_fall_s) begin
                        sh_s      = rd_byte_s;
                        sda_low_s = ~rd_byte_s[7];
                        cnt_s     = 4'd0;
                        state_s   = ST_RD_DATA;
                    end else begin
                        sda_low_s = 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise_s) begin
                        cnt_s = cnt_r + 4'd1;
                    end else if (scl_fall_s && cnt_r == 4'd8) begin
                        sda_low_s = 1'b0;
                        cnt_s     = 4'd0;
                        state_s   = ST_RD_ACK;
                    end else if (scl_fall_s) begin
                        sh_s      = {sh_r[6:0], 1'b0};
                        sda_low_s = ~sh_r[6];
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                // cnt_r==1 marks "master acknowledged"; the next byte is loaded on the following fall.
                ST_RD_ACK: begin
                    if (scl_rise_s && sda_in_s) begin
                        state_s = ST_IGNORE;
                    end else if (scl_rise_s) begin
                        ptr_s = ptr_r + PW'(1);
                        cnt_s = 4'd1;
                    end else if (scl_fall_s && cnt_r == 4'd1) begin
                        sh_s      = rd_byte_s;
                        sda_low_s = ~rd_byte_s[7];
                        cnt_s     = 4'd0;
                        state_s   = ST_RD_DATA;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    state_s = state_r;
                end
                default: begin
                    state_s   = ST_IDLE;
                    sda_low_s = 1'b0;
                end
            endcase
        end
    end

    // Protocol state and datapath registers; sda release on reset is immediate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            sh_r      <= 8'h00;
            ptr_r     <= {PW{1'b0}};
            sda_low_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            sh_r      <= sh_s;
            ptr_r     <= ptr_s;
            sda_low_r <= sda_low_s;
            busy_r    <= busy_s;
        end
    end

    // Storage array, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
        end else if (commit_s) begin
            mem_r[ptr_r] <= sh_r;
        end
    end

    // Registered write-status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pulse_r <= 1'b0;
            wr_addr_r  <= 8'h00;
            last_wr_r  <= 8'h00;
        end else begin
            wr_pulse_r <= commit_s;
            if (commit_s) begin
                wr_addr_r <= 8'(ptr_r);
                last_wr_r <= sh_r;
            end
        end
    end
endmodule

// File: tb/tb_iic_slave_mem.sv
`timescale 1ns/1ps
// Bench for iic_slave_mem: bit-banged I2C master, EEPROM model with a word pointer,
// directed scenarios followed by random write / random-read / current-read transactions.
module tb_iic_slave_mem;
    localparam int Q = 60;   // quarter SCL period, 6 clk

    logic clk = 1'b0;
    logic rst;
    logic sda_m;
    wire  sda;
    iic_slave_mem_if bus();

    iic_slave_mem #(.DEV_ADDR(7'h50), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .sda(sda), .bus(bus)
    );

    assign sda = sda_m ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    int slave_pulls = 0;

    always @(negedge clk) begin
        if (bus.wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if (sda_m === 1'b1 && sda === 1'b0) slave_pulls <= slave_pulls + 1;
    end

    logic [7:0] ref_mem [16];
    int         ref_ptr;
    int         ref_pulses;
    logic [7:0] ref_last, ref_waddr;
    bit         ptr_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_bit(input logic b);
        sda_m = b; #(Q);
        bus.scl = 1'b1; #(2*Q);
        bus.scl = 1'b0; #(Q);
    endtask

    task automatic m_rd_bit(output logic b);
        sda_m = 1'b1; #(Q);
        bus.scl = 1'b1; #(Q);
        b = sda; #(Q);
        bus.scl = 1'b0; #(Q);
    endtask

    task automatic m_start();
        sda_m = 1'b1; #(Q);
        bus.scl = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        bus.scl = 1'b0; #(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; #(Q);
        bus.scl = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic m_wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit(d[i]);
        m_rd_bit(ack);
    endtask

    task automatic m_rd_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_rd_bit(b);
            d[i] = b;
        end
        m_bit(nack);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(ref_waddr));
        check_eq({tag, ".last_wr"}, 32'(bus.last_wr), 32'(ref_last));
        check_eq({tag, ".pulses"}, 32'(pulse_cnt), 32'(ref_pulses));
    endtask

    // Write n bytes (dat[7:0] first) starting at word address a, then STOP.
    task automatic do_write(input logic [7:0] a, input int n, input logic [31:0] dat, input string tag);
        logic ack;
        logic [7:0] d;
        m_start();
        m_wr_byte(8'hA0, ack);
        check_eq({tag, ".dev_ack"}, 32'(ack), 32'd0);
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
        m_wr_byte(a, ack);
        check_eq({tag, ".wa_ack"}, 32'(ack), 32'd0);
        ref_ptr = int'(a) % 16;
        for (int i = 0; i < n; i++) begin
            d = dat[8*i +: 8];
            m_wr_byte(d, ack);
            check_eq({tag, ".data_ack"}, 32'(ack), 32'd0);
            ref_mem[ref_ptr] = d;
            ref_waddr = 8'(ref_ptr);
            ref_last = d;
            ref_pulses++;
            ref_ptr = (ref_ptr + 1) % 16;
        end
        m_stop();
        check_status(tag);
        ptr_known = 1'b1;
    endtask

    // Read n bytes, ACK all but the last; rnd selects random read (word address + repeated START).
    task automatic do_read(input bit rnd, input logic [7:0] a, input int n, input string tag);
        logic ack;
        logic [7:0] d;
        m_start();
        if (rnd) begin
            m_wr_byte(8'hA0, ack);
            check_eq({tag, ".dev_ack"}, 32'(ack), 32'd0);
            m_wr_byte(a, ack);
            check_eq({tag, ".wa_ack"}, 32'(ack), 32'd0);
            ref_ptr = int'(a) % 16;
            m_start();
        end
        m_wr_byte(8'hA1, ack);
        check_eq({tag, ".rd_ack"}, 32'(ack), 32'd0);
        for (int i = 0; i < n; i++) begin
            m_rd_byte(i == n - 1, d);
            check_eq({tag, ".data"}, 32'(d), 32'(ref_mem[ref_ptr]));
            if (i < n - 1) ref_ptr = (ref_ptr + 1) % 16;
        end
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
        m_stop();
        check_status(tag);
        ptr_known = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         kind, n, pulls0, pulses0;

        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_ptr = 0; ref_pulses = 0; ref_last = 8'h00; ref_waddr = 8'h00; ptr_known = 1'b1;
        sda_m = 1'b1;
        bus.scl = 1'b1;
        rst = 1'b1;
        #30;
        check_eq("reset.sda_released", 32'(sda), 32'd1);
        check_eq("reset.busy", 32'(bus.busy), 32'd0);
        check_eq("reset.wr_pulse", 32'(bus.wr_pulse), 32'd0);
        check_eq("reset.wr_addr", 32'(bus.wr_addr), 32'd0);
        check_eq("reset.last_wr", 32'(bus.last_wr), 32'd0);
        #10 rst = 1'b0;
        #(4*Q);

        do_write(8'h03, 1, 32'h0000_005A, "t1_byte_write");
        do_read(1'b1, 8'h03, 1, "t2_random_read");
        do_write(8'h0F, 2, 32'h0000_2211, "t3_wrap_write");
        do_read(1'b1, 8'h0F, 2, "t3_wrap_read");

        // Wrong device address: no ACK, no drive, no commit.
        pulls0 = slave_pulls;
        pulses0 = pulse_cnt;
        m_start();
        m_wr_byte(8'hA4, ack);
        check_eq("t4_wrong_dev.ack", 32'(ack), 32'd1);
        check_eq("t4_wrong_dev.busy", 32'(bus.busy), 32'd0);
        m_wr_byte(8'h03, ack);
        m_wr_byte(8'h77, ack);
        check_eq("t4_wrong_dev.data_ack", 32'(ack), 32'd1);
        m_stop();
        check_eq("t4_wrong_dev.no_drive", 32'(slave_pulls), 32'(pulls0));
        check_eq("t4_wrong_dev.no_pulse", 32'(pulse_cnt), 32'(pulses0));
        check_status("t4_wrong_dev");

        // STOP four bits into a data byte.
        do_write(8'h05, 1, 32'h0000_0099, "t5_setup");
        m_start();
        m_wr_byte(8'hA0, ack);
        m_wr_byte(8'h05, ack);
        for (int i = 0; i < 4; i++) m_bit(1'b1);
        m_stop();
        ptr_known = 1'b0;
        check_status("t5_abort");
        do_read(1'b1, 8'h05, 1, "t5_after_abort");
        do_write(8'h05, 1, 32'h0000_0042, "t5_rewrite");
        do_read(1'b1, 8'h05, 1, "t5_reread");

        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            d = 8'($urandom);
            if (kind == 2 && !ptr_known) kind = 1;
            case (kind)
                0:       do_write(d, n, $urandom, "rnd_write");
                1:       do_read(1'b1, d, n, "rnd_read");
                default: do_read(1'b0, d, n, "rnd_cur_read");
            endcase
        end

        // Reset while the slave is driving a 0 data bit.
        do_write(8'h03, 1, 32'h0000_003C, "t6_setup");
        m_start();
        m_wr_byte(8'hA0, ack);
        m_wr_byte(8'h03, ack);
        m_start();
        m_wr_byte(8'hA1, ack);
        check_eq("t6_rst.rd_ack", 32'(ack), 32'd0);
        check_eq("t6_rst.driving_bit7", 32'(sda), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("t6_rst.sda_released", 32'(sda), 32'd1);
        check_eq("t6_rst.busy", 32'(bus.busy), 32'd0);
        #19 rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_ptr = 0; ref_last = 8'h00; ref_waddr = 8'h00;
        #(Q);
        m_stop();
        check_status("t6_after_reset");
        do_read(1'b1, 8'h03, 1, "t6_read_cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
